// File: rtl/dpi_pkg.sv
// Shared types and defaults for the packet-inspection front-end sequencer.
package dpi_pkg;

  localparam int SID_W         = 6;
  localparam int NUM_STREAMS   = 1 << SID_W;
  localparam int DEF_LOAD_GAP  = 2;
  localparam int DEF_EOP_GAP   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_STREAM,
    ST_DRAIN,
    ST_EOP
  } state_e;

endpackage

// File: rtl/dpi_pkt_sequencer_if.sv
// Byte-wide packet stream carrying a stream ID on the SOP beat.
interface dpi_pkt_sequencer_if #(
  parameter int SID_W = dpi_pkg::SID_W
);
  logic             in_vld;
  logic             in_rdy;
  logic [7:0]       in_data;
  logic             in_sop;
  logic             in_eop;
  logic [SID_W-1:0] in_sid;

  modport master (output in_vld, in_data, in_sop, in_eop, in_sid, input in_rdy);
  modport slave  (input in_vld, in_data, in_sop, in_eop, in_sid, output in_rdy);
endinterface

// File: rtl/dpi_stream_table.sv
// Per-stream seen bitmap and enable mask; combinational read, registered updates.
module dpi_stream_table #(
  parameter int NUM_STREAMS = dpi_pkg::NUM_STREAMS,
  parameter int SID_W       = dpi_pkg::SID_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SID_W-1:0] rd_sid,
  output logic             rd_seen,
  output logic             rd_en,
  input  logic             set_vld,
  input  logic [SID_W-1:0] set_sid,
  input  logic             wr_vld,
  input  logic [SID_W-1:0] wr_sid,
  input  logic             wr_en,
  input  logic             clr
);
  logic [NUM_STREAMS-1:0] seen_q;
  logic [NUM_STREAMS-1:0] mask_q;

  assign rd_seen = seen_q[rd_sid];
  assign rd_en   = mask_q[rd_sid];

  // NOTE: these tables are small flop vectors with defined power-up contents,
  // so they are reset; RAM-backed tables would be left unreset.
  // The later set overrides the clear, so clear-then-set in one cycle works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= '0;
      mask_q <= '0;
    end else begin
      if (clr)     seen_q <= '0;
      if (set_vld) seen_q[set_sid] <= 1'b1;
      if (wr_vld)  mask_q[wr_sid] <= wr_en;
    end
  end

endmodule

// File: rtl/dpi_pkt_sequencer.sv
// Drives regex-lane controls from a tagged byte stream, enforcing the
// state-restore gap before data and the result-settle gap before eop.
module dpi_pkt_sequencer #(
  parameter int NUM_STREAMS = dpi_pkg::NUM_STREAMS,
  parameter int SID_W       = dpi_pkg::SID_W,
  parameter int LOAD_GAP    = dpi_pkg::DEF_LOAD_GAP,
  parameter int EOP_GAP     = dpi_pkg::DEF_EOP_GAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpi_pkt_sequencer_if.slave   in_if,
  input  logic                 cfg_we,
  input  logic [SID_W-1:0]     cfg_sid,
  input  logic                 cfg_en,
  input  logic                 clr_seen,
  output logic                 load_state,
  output logic                 new_stream_id,
  output logic [SID_W-1:0]     stream_id,
  output logic                 enable,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic                 busy,
  output logic [15:0]          pkt_count,
  output logic                 proto_err
);
  import dpi_pkg::*;

  localparam logic [7:0] LOAD_CNT  = 8'(LOAD_GAP > 2 ? LOAD_GAP - 3 : 0);
  localparam logic [7:0] DRAIN_CNT = 8'(EOP_GAP > 1 ? EOP_GAP - 2 : 0);

  state_e           state_q, state_d;
  logic [7:0]       gap_q, gap_d;
  logic [SID_W-1:0] sid_q;
  logic             enable_q, first_q, drop_q;
  logic [7:0]       char_q;
  logic             char_vld_q, eop_q, proto_err_q;
  logic [15:0]      pkt_cnt_q;
  logic             rdy, accept, tbl_seen, tbl_en;

  dpi_stream_table #(.NUM_STREAMS(NUM_STREAMS), .SID_W(SID_W)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_sid  (sid_q),
    .rd_seen (tbl_seen),
    .rd_en   (tbl_en),
    .set_vld (load_state),
    .set_sid (sid_q),
    .wr_vld  (cfg_we),
    .wr_sid  (cfg_sid),
    .wr_en   (cfg_en),
    .clr     (clr_seen)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rdy     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A stray non-SOP beat is swallowed one cycle after it is seen, which
        // keeps in_rdy free of any combinational path from in_vld.
        rdy = drop_q;
        if (!drop_q && in_if.in_vld && in_if.in_sop) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (LOAD_GAP > 2) begin
          state_d = ST_GAP;
          gap_d   = LOAD_CNT;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) state_d = ST_STREAM;
        else               gap_d   = gap_q - 8'd1;
      end
      ST_STREAM: begin
        rdy = 1'b1;
        if (in_if.in_vld && in_if.in_eop) begin
          if (EOP_GAP > 1) begin
            state_d = ST_DRAIN;
            gap_d   = DRAIN_CNT;
          end else begin
            state_d = ST_EOP;
          end
        end
      end
      ST_DRAIN: begin
        if (gap_q == 8'd0) state_d = ST_EOP;
        else               gap_d   = gap_q - 8'd1;
      end
      ST_EOP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = (state_q == ST_STREAM) && in_if.in_vld;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gap_q       <= 8'd0;
      sid_q       <= '0;
      enable_q    <= 1'b0;
      first_q     <= 1'b0;
      drop_q      <= 1'b0;
      char_q      <= 8'd0;
      char_vld_q  <= 1'b0;
      eop_q       <= 1'b0;
      pkt_cnt_q   <= 16'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      drop_q  <= (state_q == ST_IDLE) && !drop_q && in_if.in_vld && !in_if.in_sop;
      if ((state_q == ST_IDLE) && !drop_q && in_if.in_vld) begin
        if (in_if.in_sop) sid_q       <= in_if.in_sid;
        else              proto_err_q <= 1'b1;
      end
      if (state_q == ST_LOAD) begin
        enable_q <= tbl_en;
        first_q  <= 1'b1;
      end
      char_vld_q <= accept;
      if (accept) begin
        char_q  <= in_if.in_data;
        first_q <= 1'b0;
        if (in_if.in_sop && !first_q) proto_err_q <= 1'b1;
      end
      eop_q <= (state_q == ST_EOP);
      if (state_q == ST_EOP) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign in_if.in_rdy  = rdy;
  assign load_state    = (state_q == ST_LOAD);
  assign new_stream_id = load_state && !tbl_seen;
  // Mask is shown live during LOAD, then held from the latched copy.
  assign enable        = load_state ? tbl_en : enable_q;
  assign stream_id     = sid_q;
  assign char_in       = char_q;
  assign char_in_vld   = char_vld_q;
  assign eop           = eop_q;
  assign busy          = (state_q != ST_IDLE);
  assign pkt_count     = pkt_cnt_q;
  assign proto_err     = proto_err_q;

endmodule
